// File: rtl/spi_regfile_rw_if.sv
// -----------------------------------------------------------------------------
// spi_regfile_rw_if
// Chip-level SPI pin bundle for the SPI register file.
//   spi_sclk_i    : SPI clock (mode 0), asynchronous to the system clock
//   spi_mosi_i    : serial data into the slave, MSB first
//   spi_cs_ni     : chip select, active-low
//   spi_miso_o    : serial data out of the slave
//   spi_miso_oe_o : MISO pad drive enable
// Modports: slave (the register file), master (the pad ring / test driver).
// -----------------------------------------------------------------------------
interface spi_regfile_rw_if;
   logic spi_sclk_i;
   logic spi_mosi_i;
   logic spi_cs_ni;
   logic spi_miso_o;
   logic spi_miso_oe_o;

   modport slave (
      input  spi_sclk_i,
      input  spi_mosi_i,
      input  spi_cs_ni,
      output spi_miso_o,
      output spi_miso_oe_o
   );

   modport master (
      output spi_sclk_i,
      output spi_mosi_i,
      output spi_cs_ni,
      input  spi_miso_o,
      input  spi_miso_oe_o
   );
endinterface

// File: rtl/spi_regfile_rw.sv
// -----------------------------------------------------------------------------
// spi_regfile_rw
// Parametrised SPI (mode 0) slave register file with read-back and
// auto-increment burst access. A transaction is a command byte
// (bit7 = R/nW, bits[6:0] = start address) followed by any number of
// DATA_W-bit frames until chip select is released.
//
// Ports:
//   clk_i        : system clock (SCLK must be <= clk_i/4)
//   rst_ni       : asynchronous active-low reset
//   enable_i     : block enable; low behaves exactly like CS released
//   spi          : SPI pin bundle (spi_regfile_rw_if.slave)
//   regs_o       : flattened register contents, reg i at [i*DATA_W +: DATA_W]
//   wr_strobe_o  : one-cycle pulse on the cycle register i takes a new value
//
// Optional feature (macro SPI_ABORT_CNT_EN): read-only saturating count of
// aborted frames at address NUM_REGS, cleared by a completed read of it;
// the auto-increment wrap point moves to NUM_REGS.
// -----------------------------------------------------------------------------
module spi_regfile_rw #(
   parameter int                          NUM_REGS     = 8,
   parameter int                          DATA_W       = 8,
   parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VALUES = '0
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        enable_i,
   spi_regfile_rw_if.slave             spi,
   output logic [NUM_REGS*DATA_W-1:0]  regs_o,
   output logic [NUM_REGS-1:0]         wr_strobe_o
);

   // Input shifter must hold the 7 bits preceding the last command bit and
   // the DATA_W-1 bits preceding the last data bit.
   localparam int SH_W  = (DATA_W > 8) ? DATA_W - 1 : 7;
   localparam int CNT_W = 6;
`ifdef SPI_ABORT_CNT_EN
   localparam int WRAP  = NUM_REGS + 1;
`else
   localparam int WRAP  = NUM_REGS;
`endif
   localparam logic [6:0] LAST_ADDR = 7'(WRAP - 1);

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA} state_t;

   state_t              r_state, w_state_nxt;
   logic                r_sclk_p0, r_sclk_p1, r_sclk_p2;
   logic                r_mosi_p0, r_mosi_p1;
   logic                r_cs_p0, r_cs_p1;
   logic [CNT_W-1:0]    r_cnt;
   logic [6:0]          r_addr;
   logic [SH_W-1:0]     r_shin;
   logic [DATA_W-1:0]   r_shout;
   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_strobe;

   logic                w_rise, w_fall, w_active;
   logic                w_cmd_rw, w_cmd_done, w_shift_in, w_wr_commit;
   logic                w_rd_shift, w_rd_frame_done;
   logic [6:0]          w_cmd_addr, w_addr_inc, w_rd_addr;
   logic [DATA_W-1:0]   w_wr_data, w_rd_val;

`ifdef SPI_ABORT_CNT_EN
   logic [DATA_W-1:0]   r_abort_cnt;
   logic                w_abort;

   function automatic logic [DATA_W-1:0] f_sat_inc(input logic [DATA_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction
`endif

   // ---- stage p0/p1: two-flop synchronisers, p2: previous SCLK for edges ----
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sclk_p0 <= 1'b0;  r_sclk_p1 <= 1'b0;  r_sclk_p2 <= 1'b0;
         r_mosi_p0 <= 1'b0;  r_mosi_p1 <= 1'b0;
         r_cs_p0   <= 1'b1;  r_cs_p1   <= 1'b1;
      end else begin
         r_sclk_p0 <= spi.spi_sclk_i;  r_sclk_p1 <= r_sclk_p0;  r_sclk_p2 <= r_sclk_p1;
         r_mosi_p0 <= spi.spi_mosi_i;  r_mosi_p1 <= r_mosi_p0;
         r_cs_p0   <= spi.spi_cs_ni;   r_cs_p1   <= r_cs_p0;
      end
   end

   assign w_rise     = r_sclk_p1 & ~r_sclk_p2;
   assign w_fall     = ~r_sclk_p1 & r_sclk_p2;
   assign w_active   = ~r_cs_p1 & enable_i;
   assign w_cmd_rw   = r_shin[6];
   assign w_cmd_addr = {r_shin[5:0], r_mosi_p1};
   assign w_wr_data  = {r_shin[DATA_W-2:0], r_mosi_p1};
   // Out-of-range start addresses run on to 127 and then wrap naturally.
   assign w_addr_inc = (r_addr == LAST_ADDR) ? 7'd0 : r_addr + 7'd1;
   assign w_rd_addr  = (r_state == S_CMD) ? w_cmd_addr : w_addr_inc;

   always_comb begin
      w_rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (w_rd_addr == 7'(i)) w_rd_val = r_regs[i];
`ifdef SPI_ABORT_CNT_EN
      if (w_rd_addr == 7'(NUM_REGS)) w_rd_val = r_abort_cnt;
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_shift_in        = 1'b0;
      w_cmd_done        = 1'b0;
      w_wr_commit       = 1'b0;
      w_rd_shift        = 1'b0;
      w_rd_frame_done   = 1'b0;
`ifdef SPI_ABORT_CNT_EN
      w_abort           = 1'b0;
`endif
      if (!w_active) begin
         w_state_nxt = S_IDLE;
`ifdef SPI_ABORT_CNT_EN
         w_abort     = (r_state != S_IDLE) && (r_cnt != '0);
`endif
      end else begin
         case (r_state)
            S_IDLE:  w_state_nxt = S_CMD;
            S_CMD: if (w_rise) begin
               w_shift_in = 1'b1;
               if (r_cnt == CNT_W'(7)) begin
                  w_cmd_done  = 1'b1;
                  w_state_nxt = w_cmd_rw ? S_RDATA : S_WDATA;
               end
            end
            S_WDATA: if (w_rise) begin
               w_shift_in  = 1'b1;
               w_wr_commit = (r_cnt == CNT_W'(DATA_W - 1));
            end
            S_RDATA: begin
               // The falling edge right after a load belongs to the previous
               // bit, so it must not advance the shifter.
               w_rd_shift      = w_fall && (r_cnt != '0);
               w_rd_frame_done = w_rise && (r_cnt == CNT_W'(DATA_W - 1));
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
      spi.spi_miso_oe_o = (r_state == S_RDATA) && w_active;
      spi.spi_miso_o    = (r_state == S_RDATA) ? r_shout[DATA_W-1] : 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt   <= '0;
         r_addr  <= '0;
         r_shin  <= '0;
         r_shout <= '0;
      end else begin
         if (!w_active || w_cmd_done || w_wr_commit || w_rd_frame_done)
            r_cnt <= '0;
         else if (w_rise && (r_state != S_IDLE))
            r_cnt <= r_cnt + 1'b1;

         if (w_shift_in) r_shin <= {r_shin[SH_W-2:0], r_mosi_p1};

         if (w_cmd_done)                        r_addr <= w_cmd_addr;
         else if (w_wr_commit || w_rd_frame_done) r_addr <= w_addr_inc;

         if ((w_cmd_done && w_cmd_rw) || w_rd_frame_done) r_shout <= w_rd_val;
         else if (w_rd_shift)                             r_shout <= {r_shout[DATA_W-2:0], 1'b0};
      end
   end

   // ---- commit stage: register update and strobe one cycle after last rise ----
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUES[i*DATA_W +: DATA_W];
         r_strobe <= '0;
      end else begin
         r_strobe <= '0;
         if (w_wr_commit)
            for (int i = 0; i < NUM_REGS; i++)
               if (r_addr == 7'(i)) begin
                  r_regs[i]   <= w_wr_data;
                  r_strobe[i] <= 1'b1;
               end
      end
   end

`ifdef SPI_ABORT_CNT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                         r_abort_cnt <= '0;
      else if (w_abort)                                    r_abort_cnt <= f_sat_inc(r_abort_cnt);
      else if (w_rd_frame_done && r_addr == 7'(NUM_REGS)) r_abort_cnt <= '0;
   end
`endif

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
      assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
   end
   assign wr_strobe_o = r_strobe;

endmodule

// File: tb/tb_spi_regfile_rw.sv
// -----------------------------------------------------------------------------
// tb_spi_regfile_rw
// Self-checking bench for spi_regfile_rw (NUM_REGS = 8, DATA_W = 8). A
// transaction-level model (register array, address walk, abort counter when
// SPI_ABORT_CNT_EN is defined) predicts read data, register contents and
// the ordered list of write strobes for directed and random transactions.
// -----------------------------------------------------------------------------
module tb_spi_regfile_rw;
   localparam int          NUM_REGS = 8;
   localparam int          DATA_W   = 8;
   localparam logic [63:0] RV       = 64'h8877_6655_4433_2211;
`ifdef SPI_ABORT_CNT_EN
   localparam int          WRAP     = NUM_REGS + 1;
`else
   localparam int          WRAP     = NUM_REGS;
`endif
   localparam int          HALF     = 80;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        enable_i = 1'b1;
   logic [63:0] regs_o;
   logic [7:0]  wr_strobe_o;

   spi_regfile_rw_if spi_if ();

   spi_regfile_rw #(
      .NUM_REGS     (NUM_REGS),
      .DATA_W       (DATA_W),
      .RESET_VALUES (RV)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .enable_i    (enable_i),
      .spi         (spi_if.slave),
      .regs_o      (regs_o),
      .wr_strobe_o (wr_strobe_o)
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [7:0]  model [NUM_REGS];
   int          abort_cnt = 0;
   logic [7:0]  wdat [8];
   logic [7:0]  strb_q [$];
   time         strb_t [$];
   logic [7:0]  exp_strb [$];
   time         t_rise = 0;

   always @(negedge clk)
      if (rst_ni && wr_strobe_o != 8'h00) begin
         strb_q.push_back(wr_strobe_o);
         strb_t.push_back($time);
      end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model_flat();
      logic [63:0] r;
      for (int i = 0; i < NUM_REGS; i++) r[i*8 +: 8] = model[i];
      return r;
   endfunction

   function automatic int next_addr(input int a);
      return (a == WRAP - 1) ? 0 : (a + 1) % 128;
   endfunction

   function automatic logic [7:0] read_model(input int a);
      if (a < NUM_REGS) return model[a];
`ifdef SPI_ABORT_CNT_EN
      if (a == NUM_REGS) return 8'(abort_cnt);
`endif
      return 8'h00;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM_REGS; i++) model[i] = RV[i*8 +: 8];
      abort_cnt = 0;
   endtask

   // Mode 0 master: MOSI set while SCLK low, MISO sampled just before the rise.
   task automatic spi_bits(input logic [7:0] tx, input int nbits,
                           output logic [7:0] rx, output logic [7:0] oe);
      rx = 8'h00;
      oe = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_if.spi_mosi_i = tx[7-i];
         #HALF;
         rx[7-i] = spi_if.spi_miso_o;
         oe[7-i] = spi_if.spi_miso_oe_o;
         spi_if.spi_sclk_i = 1'b1;
         t_rise = $time;
         #HALF;
         spi_if.spi_sclk_i = 1'b0;
      end
   endtask

   task automatic cs_low();
      @(negedge clk);
      strb_q.delete();
      strb_t.delete();
      exp_strb.delete();
      spi_if.spi_cs_ni = 1'b0;
      #HALF;
   endtask

   task automatic cs_high();
      #HALF;
      spi_if.spi_cs_ni  = 1'b1;
      spi_if.spi_mosi_i = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic check_end();
      int n;
      chk("regs", regs_o, model_flat());
      chk("strb_count", 64'(strb_q.size()), 64'(exp_strb.size()));
      n = (strb_q.size() < exp_strb.size()) ? strb_q.size() : exp_strb.size();
      for (int i = 0; i < n; i++) chk("strb_value", strb_q[i], exp_strb[i]);
      chk("idle_miso_oe", {spi_if.spi_miso_o, spi_if.spi_miso_oe_o}, 2'b00);
   endtask

   // One transaction: command, nfr full frames, then optionally 'part' bits of
   // an unfinished frame before CS is released.
   task automatic xact(input logic rw, input logic [6:0] a0, input int nfr, input int part);
      logic [7:0] rx, oe, ev;
      int a;
      cs_low();
      spi_bits({rw, a0}, 8, rx, oe);
      chk("cmd_oe", oe, 8'h00);
      a = int'(a0);
      for (int f = 0; f < nfr; f++) begin
         if (rw) begin
            ev = read_model(a);
            spi_bits(8'h00, 8, rx, oe);
            chk("rdata", rx, ev);
            chk("rdata_oe", oe, 8'hFF);
`ifdef SPI_ABORT_CNT_EN
            if (a == NUM_REGS) abort_cnt = 0;
`endif
         end else begin
            spi_bits(wdat[f], 8, rx, oe);
            chk("wdata_oe", oe, 8'h00);
            if (a < NUM_REGS) begin
               model[a] = wdat[f];
               exp_strb.push_back(8'(1 << a));
            end
         end
         a = next_addr(a);
      end
      if (part > 0) begin
         spi_bits(8'($urandom), part, rx, oe);
         if (abort_cnt < 255) abort_cnt++;
      end
      cs_high();
`ifndef SPI_ABORT_CNT_EN
      abort_cnt = 0;
`endif
      check_end();
   endtask

   initial begin
      logic [7:0] rx, oe;
      logic       lat_ok;
      time        d;
      spi_if.spi_sclk_i = 1'b0;
      spi_if.spi_mosi_i = 1'b0;
      spi_if.spi_cs_ni  = 1'b1;
      model_reset();

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_regs", regs_o, RV);
      chk("reset_strb", wr_strobe_o, 8'h00);
      chk("reset_miso_oe", {spi_if.spi_miso_o, spi_if.spi_miso_oe_o}, 2'b00);
      rst_ni = 1'b1;
      repeat (4) @(negedge clk);

      // Single write: cmd 02, data A5
      wdat[0] = 8'hA5;
      xact(1'b0, 7'h02, 1, 0);
      chk("reg2_a5", regs_o[23:16], 8'hA5);
      d = (strb_t.size() == 1) ? strb_t[0] - t_rise : 0;
      lat_ok = (strb_t.size() == 1) && (d >= 20) && (d <= 50);
      chk("strb_latency", lat_ok, 1'b1);

      // Burst write wrapping 6 -> 7 -> 0
      wdat[0] = 8'h01; wdat[1] = 8'h02; wdat[2] = 8'h03;
      xact(1'b0, 7'h06, 3, 0);
      chk("reg0_wrap", regs_o[7:0], 8'h03);

      // Burst read of reg1/reg2 after loading 3C, C3
      wdat[0] = 8'h3C; wdat[1] = 8'hC3;
      xact(1'b0, 7'h01, 2, 0);
      xact(1'b1, 7'h01, 2, 0);

      // Aborted write frame (5 bits) to reg3, then a normal write
      xact(1'b0, 7'h03, 0, 5);
      wdat[0] = 8'h5A;
      xact(1'b0, 7'h03, 1, 0);
`ifdef SPI_ABORT_CNT_EN
      xact(1'b1, 7'(NUM_REGS), 1, 0);
      xact(1'b1, 7'(NUM_REGS), 1, 0);
`endif

      // Out-of-range write and read
      wdat[0] = 8'hEE;
      xact(1'b0, 7'h7F, 1, 0);
      xact(1'b1, 7'h0A, 1, 0);

      // Whole transaction with the block disabled has no effect
      enable_i = 1'b0;
      cs_low();
      spi_bits(8'h04, 8, rx, oe);
      spi_bits(8'h99, 8, rx, oe);
      chk("disabled_oe", oe, 8'h00);
      cs_high();
      enable_i = 1'b1;
      check_end();

      // Asynchronous reset in the middle of a write frame
      cs_low();
      spi_bits(8'h05, 8, rx, oe);
      spi_bits(8'hF0, 4, rx, oe);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("async_reset_regs", regs_o, RV);
      model_reset();
      spi_if.spi_cs_ni = 1'b1;
      repeat (4) @(negedge clk);
      rst_ni = 1'b1;
      repeat (4) @(negedge clk);
      strb_q.delete();
      exp_strb.delete();
      check_end();

      // Random transactions
      for (int n = 0; n < 40; n++) begin
         logic       rw;
         logic [6:0] a;
         int         nfr, part;
         rw   = 1'($urandom_range(0, 1));
         a    = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(120, 127))
                                            : 7'($urandom_range(0, 10));
         nfr  = $urandom_range(1, 4);
         part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
         for (int i = 0; i < 8; i++) wdat[i] = 8'($urandom);
         xact(rw, a, nfr, part);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
